// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - byte-stream program image loader feeding Program_Memory
//
// Receives a program image as a valid/ready byte stream and writes it into
// program memory as little-endian 32-bit words, holding the core in reset
// until the whole image has been written.
//
// Stream: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes
// [, checksum byte when LOADER_CHECKSUM_EN is defined].
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   - one trailing byte must equal the XOR of all data bytes,
//               otherwise the load ends in ERROR.
//   undefined - DONE follows the last word write directly.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   start_i        in   begin a load (honoured in IDLE, DONE, ERROR)
//   byte_valid_i   in   byte_data_i holds a valid byte
//   byte_data_i    in   stream byte
//   byte_ready_o   out  loader accepts a byte this cycle
//   mem_write_o    out  program memory write strobe, one cycle per word
//   mem_addr_o     out  byte address of the word written
//   mem_data_o     out  word written
//   core_reset_n_o out  active-low core reset, high only in DONE
//   busy_o         out  load in progress
//   done_o         out  image loaded, core released
//   error_o        out  load aborted

module program_memory_loader #(
    parameter int          PROGRAM_MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR            = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        core_reset_n_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    // One extra bit so that idx can reach DEPTH itself when N == DEPTH.
    localparam int IDX_W = $clog2(PROGRAM_MEMORY_DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_e;

    // Where the FSM goes once the image body is complete.
`ifdef LOADER_CHECKSUM_EN
    localparam state_e S_AFTER_IMAGE = S_CHECK;
`else
    localparam state_e S_AFTER_IMAGE = S_DONE;
`endif

    state_e           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [23:0]      word_q, word_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             xfer;
    logic [15:0]      len_full;
    logic [IDX_W-1:0] idx_inc;

    assign byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
`ifdef LOADER_CHECKSUM_EN
                          (state_q == S_CHECK) ||
`endif
                          (state_q == S_DATA);
    assign mem_write_o    = (state_q == S_WRITE);
    assign mem_addr_o     = addr_q;
    assign mem_data_o     = data_q;
    assign core_reset_n_o = (state_q == S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign error_o        = (state_q == S_ERROR);
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE) &&
                            (state_q != S_ERROR);

    assign xfer     = byte_valid_i && byte_ready_o;
    assign len_full = {byte_data_i, len_q[7:0]};
    assign idx_inc  = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN_LO;
                    idx_d   = '0;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d   = {8'h00, byte_data_i};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = S_AFTER_IMAGE;
                    end else if ({16'd0, len_full} > 32'(PROGRAM_MEMORY_DEPTH)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data_i;
`endif
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Latch the write address/data now so they are stable
                        // during WRITE and hold afterwards.
                        addr_d  = BASE_ADDR + {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
                        data_d  = {byte_data_i, word_q};
                        state_d = S_WRITE;
                    end else begin
                        // Shift in from the top so the first byte ends in [7:0].
                        word_d = {byte_data_i, word_q[23:8]};
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_inc;
                if (16'(idx_inc) == len_q) begin
                    state_d = S_AFTER_IMAGE;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_d = (byte_data_i == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_memory_loader.sv
// tb/tb_program_memory_loader.sv - scoreboard bench for program_memory_loader
//
// Expected word writes are queued as each word's bytes are driven and popped
// when mem_write_o strobes. Set LOADER_CHECKSUM_EN to exercise the CHECK state.

module tb_program_memory_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        core_reset_n_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    program_memory_loader #(
        .PROGRAM_MEMORY_DEPTH(64),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_i(start_i),
        .byte_valid_i(byte_valid_i),
        .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o),
        .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .core_reset_n_o(core_reset_n_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] sb_exp;
    int          widx;
    logic [7:0]  tb_csum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // {byte_ready, mem_write, core_reset_n, busy, done, error}
    function automatic logic [31:0] flags();
        return {26'd0, byte_ready_o, mem_write_o, core_reset_n_o, busy_o, done_o, error_o};
    endfunction

    always @(negedge clk) begin
        if (reset && mem_write_o) begin
            if (sb_q.size() == 0) begin
                check("write_expected", 32'(sb_q.size()), 32'd1);
            end else begin
                sb_exp = sb_q.pop_front();
                check("wr_addr", mem_addr_o, sb_exp[63:32]);
                check("wr_data", mem_data_o, sb_exp[31:0]);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the handshake.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        while (!byte_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", 32'(byte_ready_o), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            if (toggle && i > 0) begin
                byte_valid_i = 1'b0;
                @(negedge clk);
            end
            if (i == 3) begin
                sb_q.push_back({BASE + 32'(widx) * 32'd4, w});
                widx++;
            end
            tb_csum = tb_csum ^ b;
            send_byte(b);
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic begin_load(input logic [15:0] n);
        pulse_start();
        widx    = 0;
        tb_csum = 8'h00;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    // Called at the negedge of the last WRITE; returns in DONE/ERROR.
    task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_csum);
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        reset        = 1'b0;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        check("t1_flags_in_reset", flags(), 32'h00);
        check("t1_addr_in_reset", mem_addr_o, 32'h0);
        check("t1_data_in_reset", mem_data_o, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_flags_idle", flags(), 32'h00);

        // Steady stream, valid held high throughout
        begin_load(16'd2);
        send_word(32'h00A00513, 1'b0);
        send_word(32'h00B00593, 1'b0);
        check("t2_second_strobe", 32'(mem_write_o), 32'd1);
        finish_image();
        check("t2_done_flags", flags(), 32'h0A);
        repeat (3) @(negedge clk);
        check("t2_done_holds_no_accept", flags(), 32'h0A);
        byte_valid_i = 1'b0;

        // Over-length image
        begin_load(16'd65);
        check("t3_error_flags", flags(), 32'h01);
        byte_valid_i = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_error_holds", flags(), 32'h01);
        byte_valid_i = 1'b0;

        // Empty image
        begin_load(16'd0);
        finish_image();
        check("t_n0_done", flags(), 32'h0A);
        byte_valid_i = 1'b0;

        // Exactly DEPTH words fills the memory
        begin_load(16'd64);
        for (int i = 0; i < 64; i++) begin
            send_word({8'(i), 8'hA5, 8'(~i), 8'h3C}, 1'b0);
        end
        check("t_full_last_addr", mem_addr_o, 32'h0040_00FC);
        finish_image();
        check("t_full_done", flags(), 32'h0A);
        byte_valid_i = 1'b0;

        // Toggling valid plus a stray start mid-load
        begin_load(16'd2);
        send_word(32'h00A00513, 1'b1);
        byte_valid_i = 1'b0;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("t4_start_ignored", flags(), 32'h24);
        send_word(32'h00B00593, 1'b1);
        finish_image();
        check("t4_done", flags(), 32'h0A);
        byte_valid_i = 1'b0;

        // Asynchronous reset mid-load
        begin_load(16'd2);
        send_word(32'h1234_5678, 1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        byte_valid_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t5_flags_async", flags(), 32'h00);
        check("t5_addr_async", mem_addr_o, 32'h0);
        check("t5_data_async", mem_data_o, 32'h0);
        check("t5_sb_drained", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        begin_load(16'd1);
        send_word(32'hCAFE_F00D, 1'b0);
        finish_image();
        check("t5_reload_done", flags(), 32'h0A);
        byte_valid_i = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        begin_load(16'd1);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h44);
        check("t6_csum_good", flags(), 32'h0A);
        byte_valid_i = 1'b0;
        begin_load(16'd1);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h45);
        check("t6_csum_bad", flags(), 32'h01);
        byte_valid_i = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
